// File: rtl/muldiv_hilo_ctrl.sv
// Purpose: sequences MULT/MULTU/DIV/DIVU for the execute stage and owns the HI/LO pair (MTHI/MTLO writes).
// Latency: multiply commits MUL_LAT edges after accept, divide commits 32 edges after accept; done pulses the cycle after.
// Backpressure: stall holds the pipeline while busy and in the requesting cycle; start while busy is ignored, flush aborts.
module muldiv_hilo_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] hilo_wdata,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  // Last counter value of each operation; the commit happens on the edge that leaves it.
  localparam logic [4:0] MUL_LAST = 5'(MUL_LAT - 1);
  localparam logic [4:0] DIV_LAST = 5'd31;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;      // operand magnitudes (absolute value for signed ops)
  logic [31:0] b_q, b_d;
  logic        sa_q, sa_d;    // original operand signs, forced to 0 for unsigned ops
  logic        sb_q, sb_d;
  logic [32:0] rem_q, rem_d;  // partial remainder
  logic [31:0] quo_q, quo_d;  // dividend shifts out of the top, quotient bits shift in at the bottom
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  // Datapath intermediates
  logic        op_signed;
  logic [31:0] mag_a, mag_b;
  logic [63:0] prod_mag, prod;
  logic [32:0] rem_sh, rem_diff, rem_step;
  logic        rem_ge;
  logic [31:0] quo_step;
  logic [31:0] quo_fix, rem_fix, a_orig;
  logic        quo_neg, rem_neg, div_by_zero;

  // The remainder is always below the divisor between steps, so its top bit never feeds the next shift.
  logic unused_rem_top;
  assign unused_rem_top = rem_q[32];

  assign busy  = (state_q != ST_IDLE);
  assign stall = busy | (start & ~busy & ~flush);
  assign done  = done_q;
  assign hi_o  = hi_q;
  assign lo_o  = lo_q;

  // Operand conditioning, multiplier, one restoring-divide step and the commit-time sign fix-up.
  always_comb begin
    op_signed = ~op[0];
    mag_a     = (op_signed & src_a[31]) ? -src_a : src_a;
    mag_b     = (op_signed & src_b[31]) ? -src_b : src_b;

    quo_neg     = sa_q ^ sb_q;
    rem_neg     = sa_q;
    div_by_zero = (b_q == 32'd0);

    prod_mag = {32'd0, a_q} * {32'd0, b_q};
    prod     = quo_neg ? -prod_mag : prod_mag;

    rem_sh   = {rem_q[31:0], quo_q[31]};
    rem_ge   = (rem_sh >= {1'b0, b_q});
    rem_diff = rem_sh - {1'b0, b_q};
    rem_step = rem_ge ? rem_diff : rem_sh;
    quo_step = {quo_q[30:0], rem_ge};

    quo_fix = quo_neg ? -quo_step : quo_step;
    rem_fix = rem_neg ? -rem_step[31:0] : rem_step[31:0];
    // Divide-by-zero reports the dividend as it was presented, so undo the magnitude conversion.
    a_orig  = rem_neg ? -a_q : a_q;
  end

  // Next-state, operand capture, iteration and HI/LO commit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Register writes land now; an op accepted in the same cycle overwrites them at commit.
        if (hi_we) hi_d = hilo_wdata;
        if (lo_we) lo_d = hilo_wdata;
        if (start && !flush) begin
          a_d     = mag_a;
          b_d     = mag_b;
          sa_d    = op_signed & src_a[31];
          sb_d    = op_signed & src_b[31];
          cnt_d   = 5'd0;
          rem_d   = 33'd0;
          quo_d   = mag_a;
          state_d = op[1] ? ST_DIV : ST_MUL;
        end
      end

      ST_MUL: begin
        if (flush) begin
          cnt_d   = 5'd0;
          state_d = ST_IDLE;
        end else if (cnt_q == MUL_LAST) begin
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          done_d  = 1'b1;
          cnt_d   = 5'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      ST_DIV: begin
        if (flush) begin
          cnt_d   = 5'd0;
          state_d = ST_IDLE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          if (cnt_q == DIV_LAST) begin
            if (div_by_zero) begin
              hi_d = a_orig;
              lo_d = 32'hFFFF_FFFF;
            end else begin
              hi_d = rem_fix;
              lo_d = quo_fix;
            end
            done_d  = 1'b1;
            cnt_d   = 5'd0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 5'd0;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation and clears HI/LO.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      rem_q   <= 33'd0;
      quo_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Bench for muldiv_hilo_ctrl: directed cases plus random ops against an arithmetic reference,
// expected results queued at issue and compared by an independent monitor on every done pulse.
module tb_muldiv_hilo_ctrl;
  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        resetn, start, flush, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, hilo_wdata;
  logic        stall, busy, done;
  logic [31:0] hi_o, lo_o;

  always #5 clk = ~clk;

  muldiv_hilo_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .hilo_wdata(hilo_wdata),
    .stall(stall), .busy(busy), .done(done), .hi_o(hi_o), .lo_o(lo_o)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_pass = 0;
  int          n_total = 0;
  int          busy_run = 0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    check32(name, {31'd0, act}, {31'd0, req});
  endtask

  // Reference: plain 64-bit arithmetic, C-style truncating signed division.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] ua, ub, res;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    res = 64'd0;
    case (o)
      2'b00: res = sa * sb;
      2'b01: res = ua * ub;
      default: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else if (o == 2'b10) begin
          sq  = sa / sb;
          sr  = sa % sb;
          res = (sr << 32) | (sq & 64'h0000_0000_FFFF_FFFF);
        end else begin
          res = ((ua % ub) << 32) | (ua / ub);
        end
      end
    endcase
    return res;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'h8000_0000;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'($urandom_range(0, 20));
      default: v = $urandom();
    endcase
    return v;
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation, including busy length.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check1("unexpected_done", 1'b1, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        check32("result_hi", hi_o, mon_e.hi);
        check32("result_lo", lo_o, mon_e.lo);
        check32("busy_cycles", 32'(busy_run), 32'(mon_e.lat));
      end
      busy_run = 0;
    end else if (busy === 1'b1) begin
      busy_run++;
    end else begin
      busy_run = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check1("op_completes", busy, 1'b0);
  endtask

  // Present a request in the current idle cycle, queue its expectation, and let it be accepted.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, output logic [63:0] r);
    exp_t e;
    r     = ref_model(o, a, b);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    #1;
    check1("stall_request_cycle", stall, 1'b1);
    e.hi  = r[63:32];
    e.lo  = r[31:0];
    e.lat = o[1] ? 32 : MUL_LAT;
    exp_q.push_back(e);
    tick();
    start = 1'b0;
    check1("busy_after_accept", busy, 1'b1);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    launch(o, a, b, r);
    wait_idle();
    model_hi = r[63:32];
    model_lo = r[31:0];
    check32("hi_after_commit", hi_o, model_hi);
    check32("lo_after_commit", lo_o, model_lo);
  endtask

  task automatic write_hilo(input logic wh, input logic wl, input logic [31:0] d);
    hi_we      = wh;
    lo_we      = wl;
    hilo_wdata = d;
    tick();
    hi_we = 1'b0;
    lo_we = 1'b0;
    if (wh) model_hi = d;
    if (wl) model_lo = d;
  endtask

  initial begin
    logic [63:0] r;
    int          n;
    resetn = 1'b0; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; src_a = 32'd0; src_b = 32'd0; hilo_wdata = 32'd0;
    @(posedge clk);
    #3;
    check1("reset_busy", busy, 1'b0);
    check1("reset_done", done, 1'b0);
    check1("reset_stall", stall, 1'b0);
    check32("reset_hi", hi_o, 32'd0);
    check32("reset_lo", lo_o, 32'd0);
    resetn = 1'b1;
    tick();

    // Multiply cases
    run_op(2'b00, 32'hFFFF_FFFE, 32'd3);
    check32("mult_hi", hi_o, 32'hFFFF_FFFF);
    check32("mult_lo", lo_o, 32'hFFFF_FFFA);
    run_op(2'b01, 32'hFFFF_FFFE, 32'd3);
    check32("multu_hi", hi_o, 32'h0000_0002);
    check32("multu_lo", lo_o, 32'hFFFF_FFFA);

    // Divide cases, including overflow and divide-by-zero
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    check32("div_hi", hi_o, 32'hFFFF_FFFF);
    check32("div_lo", lo_o, 32'hFFFF_FFFD);
    run_op(2'b11, 32'd100, 32'd7);
    check32("divu_hi", hi_o, 32'd2);
    check32("divu_lo", lo_o, 32'd14);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    check32("div_ovf_hi", hi_o, 32'd0);
    check32("div_ovf_lo", lo_o, 32'h8000_0000);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0);
    check32("div_zero_hi", hi_o, 32'hFFFF_FFF9);
    check32("div_zero_lo", lo_o, 32'hFFFF_FFFF);
    run_op(2'b11, 32'd5, 32'd0);
    check32("divu_zero_hi", hi_o, 32'd5);
    check32("divu_zero_lo", lo_o, 32'hFFFF_FFFF);

    // Flush at divide iteration 10: no commit, no done, registers keep their values
    launch(2'b11, 32'd1000, 32'd3, r);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    void'(exp_q.pop_back());
    check1("flush_busy", busy, 1'b0);
    check1("flush_done", done, 1'b0);
    check32("flush_hi", hi_o, model_hi);
    check32("flush_lo", lo_o, model_lo);
    repeat (40) tick();
    check32("flush_no_late_commit", lo_o, model_lo);

    // MTLO then MTHI, then both together
    write_hilo(1'b0, 1'b1, 32'h0000_1234);
    check32("mtlo_lo", lo_o, 32'h0000_1234);
    write_hilo(1'b1, 1'b0, 32'h0000_ABCD);
    check32("mthi_hi", hi_o, 32'h0000_ABCD);
    check32("mthi_lo_kept", lo_o, 32'h0000_1234);
    write_hilo(1'b1, 1'b1, 32'h5A5A_0F0F);
    check32("mthilo_hi", hi_o, model_hi);
    check32("mthilo_lo", lo_o, model_lo);

    // Writes and a new start during a divide are ignored
    launch(2'b11, 32'd100, 32'd7, r);
    repeat (4) tick();
    hi_we = 1'b1;
    hilo_wdata = 32'hDEAD_BEEF;
    tick();
    hi_we = 1'b0;
    check32("busy_write_ignored", hi_o, model_hi);
    start = 1'b1; op = 2'b00; src_a = 32'd7; src_b = 32'd9;
    tick();
    start = 1'b0;
    check1("busy_start_busy", busy, 1'b1);
    wait_idle();
    model_hi = r[63:32];
    model_lo = r[31:0];
    check32("busy_start_ignored_lo", lo_o, 32'd14);

    // Flush and start in the same idle cycle: no accept
    start = 1'b1; flush = 1'b1; op = 2'b10; src_a = 32'd9; src_b = 32'd2;
    #1;
    check1("flush_start_stall", stall, 1'b0);
    tick();
    start = 1'b0; flush = 1'b0;
    check1("flush_start_busy", busy, 1'b0);

    // Start and a write in the same idle cycle: write lands now, result later
    lo_we = 1'b1;
    hilo_wdata = 32'h0000_5555;
    launch(2'b00, 32'hFFFF_FFFB, 32'd6, r);
    lo_we = 1'b0;
    check32("start_write_lo_now", lo_o, 32'h0000_5555);
    wait_idle();
    model_hi = r[63:32];
    model_lo = r[31:0];
    check32("start_write_lo_later", lo_o, 32'hFFFF_FFE2);

    // Back-to-back: start held high through the done cycle
    launch(2'b11, 32'd1000, 32'd10, r);
    start = 1'b1; op = 2'b01; src_a = 32'd70000; src_b = 32'd70000;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check1("b2b_done_seen", done, 1'b1);
    check32("b2b_first_lo", lo_o, 32'd100);
    check1("b2b_stall_in_done", stall, 1'b1);
    begin
      exp_t e;
      r = ref_model(2'b01, 32'd70000, 32'd70000);
      e.hi = r[63:32];
      e.lo = r[31:0];
      e.lat = MUL_LAT;
      exp_q.push_back(e);
    end
    tick();
    start = 1'b0;
    check1("b2b_second_accepted", busy, 1'b1);
    wait_idle();
    model_hi = r[63:32];
    model_lo = r[31:0];

    // Random operations with occasional register writes in between
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        write_hilo(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom());
        check32("rand_write_hi", hi_o, model_hi);
        check32("rand_write_lo", lo_o, model_lo);
      end
      run_op(2'($urandom_range(0, 3)), pick(), pick());
    end

    // Asynchronous reset in the middle of a multiply
    launch(2'b00, 32'd12345, 32'd678, r);
    #2;
    resetn = 1'b0;
    #1;
    void'(exp_q.pop_back());
    model_hi = 32'd0;
    model_lo = 32'd0;
    check1("midreset_busy", busy, 1'b0);
    check1("midreset_done", done, 1'b0);
    check1("midreset_stall", stall, 1'b0);
    check32("midreset_hi", hi_o, 32'd0);
    check32("midreset_lo", lo_o, 32'd0);
    #3;
    resetn = 1'b1;
    tick();
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check32("multu_max_hi", hi_o, 32'hFFFF_FFFE);
    check32("multu_max_lo", lo_o, 32'h0000_0001);

    repeat (3) tick();
    check32("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo_ctrl.md
# muldiv_hilo_ctrl

Sequencer for the multi-cycle multiply/divide unit and owner of the HI/LO register pair in the MIPS core's execute stage. It accepts MULT/MULTU/DIV/DIVU requests decoded in execute and runs a fixed-latency multiply or a 32-step restoring divide. It raises a pipeline stall while busy and commits results to HI/LO. It also services MTHI/MTLO writes and aborts in-flight operations on an exception flush.

## Interface
Parameters:
- MUL_LAT, 2, multiply latency in cycles (legal range 1–4)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  request a new operation this cycle
- op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  in  32  rs operand (dividend / multiplicand)
- src_b  in  32  rt operand (divisor / multiplier)
- flush  in  1  exception flush; aborts any operation in flight
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- hilo_wdata  in  32  MTHI/MTLO data
- stall  out  1  freeze upstream pipeline
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse after a result is committed
- hi_o  out  32  HI register
- lo_o  out  32  LO register

## Operation
- States: IDLE, MUL, DIV.
- IDLE -> MUL: start=1, op[1]=0, flush=0.
- IDLE -> DIV: start=1, op[1]=1, flush=0.
- On accept, the block latches operands, op, and sign flags. For signed ops it latches |src_a| and |src_b|.
- MUL: a counter runs MUL_LAT cycles, then the 64-bit product commits as {HI,LO}.
- MULT is signed 32x32. MULTU is unsigned.
- DIV is a restoring divider, one quotient bit per cycle, 32 cycles. It uses a 33-bit partial remainder and a shift register that holds the quotient.
- Signed DIV sign fix-up happens at commit:
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- All arithmetic is modulo 2^32. 0x80000000 / -1 gives LO=0x80000000, HI=0.
- Divide by zero, both ops: LO=0xFFFFFFFF, HI=src_a (original, unsigned-unmodified). Latency is the same 32 cycles.
- Commit writes LO=quotient, HI=remainder, then returns to IDLE.
- start while busy is ignored.
- flush while busy returns to IDLE at the next edge. HI/LO are unchanged and done is not pulsed.
- flush and start in the same IDLE cycle: start is ignored.
- MTHI/MTLO:
  - In IDLE, hi_we/lo_we write hilo_wdata at the next edge. Both may be set in the same cycle.
  - While busy, hi_we/lo_we are ignored.
  - Start and a write in the same IDLE cycle: the write applies now; the op result overwrites later.

## Timing
- Reset: state=IDLE, busy=0, done=0, hi_o=0, lo_o=0, counters=0.
- stall = busy | (start & ~busy & ~flush). This is combinational, so the requesting instruction stalls in its own cycle.
- Accept edge E0. busy=1 from after E0 until the commit edge.
- DIV commits at edge E32. busy is high for 32 cycles.
- MUL commits at edge E(MUL_LAT).
- done=1 for exactly the one cycle following the commit edge. busy=0 in that same cycle, and a new start is accepted in it.
- Back-to-back: start held high across the done cycle begins the next op immediately.
- Reset mid-operation: immediate return to the reset values. The partial result is discarded.

## Test plan
- MULT src_a=0xFFFFFFFE (-2), src_b=3, MUL_LAT=2 -> stall in cycle 0, commit at E2 with HI=0xFFFFFFFF and LO=0xFFFFFFFA; MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV src_a=-7 (0xFFFFFFF9), src_b=2 -> 32 busy cycles, then LO=0xFFFFFFFD and HI=0xFFFFFFFF with done pulsing once; DIVU 100/7 -> LO=14, HI=2.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0; DIVU 5/0 -> LO=0xFFFFFFFF, HI=5, after 32 cycles.
- Start a DIV, assert flush at iteration 10 -> IDLE at the next edge, HI/LO keep their prior values, no done, busy=0.
- Sequence the register writes and a busy-time start:
  - MTLO 0x1234 in IDLE, then MTHI 0xABCD -> lo_o=0x1234, hi_o=0xABCD.
  - hi_we while a DIV is busy -> ignored.
  - start pulsed mid-DIV -> ignored, and the original result commits.
- Assert resetn=0 mid-MUL -> all outputs 0 asynchronously; after release, MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
